// File: rtl/sram_req_ctrl.sv
// Single-outstanding request sequencer for an external SRAM pin wrapper: read/write timing, registered pins, response pulse.
// Define SRAM_CTRL_POSTED_WR_EN to acknowledge writes in the setup cycle instead of after the hold cycle.
module sram_req_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [ADDR_W-1:0]     io_req_addr,
    input  logic                  io_req_we,
    input  logic [DATA_W-1:0]     io_req_wdata,
    input  logic [DATA_W/8-1:0]   io_req_wmask,
    output logic                  io_resp_valid,
    output logic [DATA_W-1:0]     io_resp_rdata,
    output logic [ADDR_W-1:0]     io_sram_addr,
    output logic [DATA_W-1:0]     io_sram_din,
    output logic                  io_sram_en,
    output logic                  io_sram_re,
    output logic                  io_sram_we,
    output logic [DATA_W/8-1:0]   io_sram_wmask,
    input  logic [DATA_W-1:0]     io_sram_dout
);

    localparam int MASK_W   = DATA_W / 8;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WSETUP = 3'd2;
    localparam logic [2:0] ST_WPULSE = 3'd3;
    localparam logic [2:0] ST_WHOLD  = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic [MASK_W-1:0] wmask_reg, wmask_next;
    logic              en_reg, en_next;
    logic              re_reg, re_next;
    logic              we_reg, we_next;
    logic              resp_valid_reg, resp_valid_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;

    assign io_req_ready  = (state_reg == ST_IDLE);
    assign io_resp_valid = resp_valid_reg;
    assign io_resp_rdata = rdata_reg;
    assign io_sram_addr  = addr_reg;
    assign io_sram_din   = din_reg;
    assign io_sram_en    = en_reg;
    assign io_sram_re    = re_reg;
    assign io_sram_we    = we_reg;
    assign io_sram_wmask = wmask_reg;

    // Next-state values are the next pin values: every io_sram_* output comes straight from a flop.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        addr_next       = addr_reg;
        din_next        = din_reg;
        wmask_next      = wmask_reg;
        en_next         = en_reg;
        re_next         = re_reg;
        we_next         = we_reg;
        resp_valid_next = 1'b0;
        rdata_next      = '0;
        case (state_reg)
            ST_IDLE: begin
                en_next    = 1'b0;
                re_next    = 1'b0;
                we_next    = 1'b0;
                wmask_next = '0;
                if (io_req_valid) begin
                    addr_next = io_req_addr;
                    en_next   = 1'b1;
                    cnt_next  = '0;
                    if (io_req_we) begin
                        state_next = ST_WSETUP;
                        din_next   = io_req_wdata;
                        wmask_next = io_req_wmask;
`ifdef SRAM_CTRL_POSTED_WR_EN
                        resp_valid_next = 1'b1;
`else
                        resp_valid_next = 1'b0;
`endif
                    end else begin
                        state_next = ST_RD;
                        re_next    = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (cnt_reg == CNT_W'(RD_WAIT - 1)) begin
                    // Last address-hold cycle: dout is sampled on this edge.
                    state_next      = ST_IDLE;
                    en_next         = 1'b0;
                    re_next         = 1'b0;
                    resp_valid_next = 1'b1;
                    rdata_next      = io_sram_dout;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WSETUP: begin
                state_next = ST_WPULSE;
                we_next    = 1'b1;
                cnt_next   = '0;
            end
            ST_WPULSE: begin
                if (cnt_reg == CNT_W'(WR_WAIT - 1)) begin
                    state_next = ST_WHOLD;
                    we_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WHOLD: begin
                state_next = ST_IDLE;
                en_next    = 1'b0;
                wmask_next = '0;
`ifdef SRAM_CTRL_POSTED_WR_EN
                resp_valid_next = 1'b0;
`else
                resp_valid_next = 1'b1;
`endif
            end
            default: begin
                state_next = ST_IDLE;
                en_next    = 1'b0;
                re_next    = 1'b0;
                we_next    = 1'b0;
                wmask_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            addr_reg       <= '0;
            din_reg        <= '0;
            wmask_reg      <= '0;
            en_reg         <= 1'b0;
            re_reg         <= 1'b0;
            we_reg         <= 1'b0;
            resp_valid_reg <= 1'b0;
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            addr_reg       <= addr_next;
            din_reg        <= din_next;
            wmask_reg      <= wmask_next;
            en_reg         <= en_next;
            re_reg         <= re_next;
            we_reg         <= we_next;
            resp_valid_reg <= resp_valid_next;
            rdata_reg      <= rdata_next;
        end
    end

endmodule
